product_accumulator: RTL and testbench

Sequential accumulate stage directly downstream of `booth_multiplier`. It takes the signed `2*WIDTH` product stream through a valid/ready handshake and sums `COUNT` consecutive products into a wide signed accumulator. Each completed sum is presented on a registered valid/ready output, together with an overflow flag. It turns the combinational multiplier into a dot-product/MAC datapath.

---
 rtl/product_accumulator_if.sv | 32 +++
 rtl/product_accumulator.sv | 110 +++++++++++
 tb/tb_product_accumulator.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/product_accumulator_if.sv
// product_accumulator_if: term input, flush and result output of the
// product accumulator bundled with a debug view of the FSM state.
//
// Handshake rules for both channels (in_valid/in_ready, out_valid/out_ready):
// a transfer happens on a rising clk edge where valid and ready are both
// high; the source holds its data stable while valid is high and not yet
// accepted, and ready never depends combinationally on valid.
interface product_accumulator_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 72
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     product;
  logic                   flush;
  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_WIDTH-1:0]   acc_out;
  logic                   overflow;
  // 0 = ACCUM, 1 = HOLD
  logic                   state_dbg;

  modport slave (
    input  in_valid, product, flush, out_ready,
    output in_ready, out_valid, acc_out, overflow, state_dbg
  );

  modport master (
    output in_valid, product, flush, out_ready,
    input  in_ready, out_valid, acc_out, overflow, state_dbg
  );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive signed products into a signed
// ACC_WIDTH accumulator and presents each completed sum, with a sticky
// overflow flag, on a registered valid/ready output.
//
// Build option: define PRODUCT_ACC_SAT_EN to clamp the running sum to the
// signed max/min on overflow; otherwise the running sum wraps modulo
// 2^ACC_WIDTH. Overflow reporting is the same either way.
//
// ACC_WIDTH must be >= 2*WIDTH and COUNT must be >= 1.
module product_accumulator #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 72,
  parameter int COUNT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int EXT   = ACC_WIDTH + 1 - PW;
  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

`ifdef PRODUCT_ACC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     cnt;
  logic                 ovf_sticky;

  logic [ACC_WIDTH:0]   sum_ext;
  logic                 ovf;
  logic [ACC_WIDTH-1:0] next_acc;
  logic                 accept;

  // in_ready comes from state (and reset) only, never from out_ready.
  assign bus.in_ready  = (state == ACCUM) && !rst;
  assign bus.state_dbg = state;
  assign accept        = bus.in_valid && bus.in_ready;

  // One extra guard bit: the top two bits of the sum disagree exactly when
  // the true sum does not fit in ACC_WIDTH signed bits.
  always_comb begin
    sum_ext  = {acc[ACC_WIDTH-1], acc} + {{EXT{bus.product[PW-1]}}, bus.product};
    ovf      = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
    next_acc = sum_ext[ACC_WIDTH-1:0];
`ifdef PRODUCT_ACC_SAT_EN
    // The guard bit carries the sign of the true sum.
    if (ovf) begin
      next_acc = sum_ext[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  // Accumulate/hold FSM with all datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf_sticky   <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.acc_out  <= '0;
      bus.overflow <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (bus.flush) begin
            // A term handshaken alongside flush is consumed and dropped.
            acc        <= '0;
            cnt        <= '0;
            ovf_sticky <= 1'b0;
          end else if (accept) begin
            if (cnt == LAST) begin
              bus.acc_out   <= next_acc;
              bus.overflow  <= ovf_sticky | ovf;
              bus.out_valid <= 1'b1;
              acc           <= '0;
              cnt           <= '0;
              ovf_sticky    <= 1'b0;
              state         <= HOLD;
            end else begin
              acc        <= next_acc;
              cnt        <= cnt + 1'b1;
              ovf_sticky <= ovf_sticky | ovf;
            end
          end
        end
        HOLD: begin
          // flush is ignored here so a pending result is never lost.
          if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vector bench for product_accumulator with
// WIDTH=8, ACC_WIDTH=18, COUNT=8.
module tb_product_accumulator;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 18;
  localparam int COUNT     = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  product_accumulator_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  product_accumulator #(
    .WIDTH(WIDTH),
    .ACC_WIDTH(ACC_WIDTH),
    .COUNT(COUNT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until an edge where in_ready was high.
  task automatic send_term(input logic signed [15:0] v);
    bit done = 0;
    bus.in_valid = 1'b1;
    bus.product  = v;
    for (int k = 0; k < 50 && !done; k++) begin
      done = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic send_n(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_term(v);
  endtask

  // Wait (bounded) for out_valid, then compare the result.
  task automatic expect_result(input string name, input int exp_acc, input logic exp_ovf);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.out_valid) seen = 1;
      else tick();
    end
    check({name, "_valid"}, int'(bus.out_valid), 1);
    check({name, "_acc"}, $signed(bus.acc_out), exp_acc);
    check({name, "_ovf"}, int'(bus.overflow), int'(exp_ovf));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string              name;
    logic signed [15:0] term;
    int                 exp_acc;
    logic               exp_ovf;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{"plus100", 16'sd100, 800, 1'b0};
`ifdef PRODUCT_ACC_SAT_EN
    vecs[1] = '{"min16", -16'sd32768, -131072, 1'b1};
    vecs[2] = '{"max16", 16'sd32767, 131071, 1'b1};
`else
    vecs[1] = '{"min16", -16'sd32768, 0, 1'b1};
    vecs[2] = '{"max16", 16'sd32767, -8, 1'b1};
`endif
    vecs[3] = '{"minus3", -16'sd3, -24, 1'b0};

    bus.in_valid  = 1'b0;
    bus.product   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // ---- reset state ----
    #2;
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_acc_out", $signed(bus.acc_out), 0);
    check("rst_overflow", int'(bus.overflow), 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    // ---- table: COUNT equal terms, out_ready high ----
    for (int i = 0; i < 4; i++) begin
      send_n(vecs[i].term, COUNT);
      expect_result(vecs[i].name, vecs[i].exp_acc, vecs[i].exp_ovf);
      tick();
      check({vecs[i].name, "_valid_one_cycle"}, int'(bus.out_valid), 0);
      check({vecs[i].name, "_in_ready_back"}, int'(bus.in_ready), 1);
    end

    // ---- backpressure in HOLD, flush ignored there ----
    bus.out_ready = 1'b0;
    send_n(16'sd10, COUNT);
    expect_result("hold", 80, 1'b0);
    bus.in_valid = 1'b1;
    bus.product  = 16'sd50;
    for (int c = 0; c < 3; c++) begin
      bus.flush = (c == 1);
      tick();
      check("hold_in_ready", int'(bus.in_ready), 0);
      check("hold_out_valid", int'(bus.out_valid), 1);
      check("hold_acc_out", $signed(bus.acc_out), 80);
    end
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("hold_release_valid", int'(bus.out_valid), 0);
    check("hold_release_in_ready", int'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    send_n(16'sd0, COUNT - 1);
    expect_result("after_hold", 50, 1'b0);
    tick();

    // ---- flush with a simultaneous term ----
    send_n(16'sd5, 3);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.product  = 16'sd7;
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    send_n(16'sd1, COUNT);
    expect_result("flush", 8, 1'b0);
    tick();

    // ---- reset mid-accumulation ----
    send_n(16'sd3, 4);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_acc_out", $signed(bus.acc_out), 0);
    check("midrst_overflow", int'(bus.overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    send_n(16'sd2, COUNT);
    expect_result("after_rst", 16, 1'b0);
    tick();

    // ---- final report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
